adder_rr_arbiter: RTL and testbench

Sequencer that shares the single 6-bit combinational `adder` (X, Y → S, cout) between two requesters. It accepts one operand pair at a time over a valid/ready handshake and registers the operands onto the adder inputs. It captures the sum and carry after one settle cycle and returns them with the requester ID over a single valid/ready response channel. It sits directly in front of the flattened-gate adder instance, which is instantiated outside this block and connected through the `add_*` ports.

---
 rtl/adder_rr_arbiter.sv | 118 +++++++++++
 tb/tb_adder_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Shares one external 6-bit adder between two requesters; optional round-robin via ADDER_ARB_RR_EN.
// Latency: accept at edge T, rsp_valid from T+2, next accept at T+3 (one op per 3 cycles).
// Backpressure: rsp_ready low holds the response; both reqN_ready stay low until it is consumed.
module adder_rr_arbiter #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant0, grant1;
    logic   accept;
    logic   handshake;

`ifdef ADDER_ARB_RR_EN
    // rr_ptr names the requester preferred on a tie
    logic rr_ptr;

    always_comb begin
        grant1 = req1_valid && (!req0_valid || rr_ptr);
        grant0 = req0_valid && !grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant0;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign accept    = (state_q == IDLE) && (grant0 || grant1);
    assign handshake = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready is masked by reset so nothing is granted while rst_n is held low
    always_comb begin
        req0_ready = rst_n && (state_q == IDLE) && grant0;
        req1_ready = rst_n && (state_q == IDLE) && grant1;
        busy       = (state_q != IDLE);
        rsp_valid  = (state_q == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_x    <= '0;
            add_y    <= '0;
            rsp_id   <= 1'b0;
            rsp_s    <= '0;
            rsp_cout <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                add_x  <= grant1 ? req1_x : req0_x;
                add_y  <= grant1 ? req1_y : req0_y;
                rsp_id <= grant1;
            end
            if (state_q == EXEC) begin
                rsp_s    <= add_s;
                rsp_cout <= add_cout;
            end
            if (handshake) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a cycle-level behavioural model and literal spot checks.
module tb_adder_rr_arbiter;

    localparam int WIDTH = 6;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [WIDTH-1:0] add_x, add_y, add_s;
    logic             add_cout;
    logic             rsp_valid, rsp_id, rsp_cout, busy;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_s;
    logic [CNT_W-1:0] op_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    // stand-in for the external adder instance
    assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y};

    adder_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_s(rsp_s), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: an op is in flight for a known number of cycles; the sum is plain arithmetic.
    logic             m_have = 1'b0;
    int               m_age = 0;
    logic             m_id = 1'b0;
    logic [WIDTH-1:0] m_ax = '0, m_ay = '0;
    logic [CNT_W-1:0] m_count = '0;
    logic             m_pref = 1'b0;

    always @(negedge clk) begin
        logic       e_r0, e_r1;
        logic [6:0] sum7;
        if (!rst_n) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_add_x", add_x, 0);
            chk("rst_add_y", add_y, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_s", rsp_s, 0);
            chk("rst_rsp_cout", rsp_cout, 0);
            chk("rst_busy", busy, 0);
            chk("rst_op_count", op_count, 0);
            m_have = 0; m_age = 0; m_id = 0; m_ax = '0; m_ay = '0; m_count = '0; m_pref = 0;
        end else begin
            e_r0 = 0;
            e_r1 = 0;
            if (!m_have) begin
`ifdef ADDER_ARB_RR_EN
                if (req0_valid && req1_valid) begin
                    e_r0 = !m_pref;
                    e_r1 = m_pref;
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
`else
                e_r0 = req0_valid;
                e_r1 = req1_valid && !req0_valid;
`endif
            end
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, m_have);
            chk("rsp_valid", rsp_valid, m_have && m_age >= 2);
            chk("add_x", add_x, m_ax);
            chk("add_y", add_y, m_ay);
            chk("op_count", op_count, m_count);
            if (m_have && m_age >= 2) begin
                sum7 = {1'b0, m_ax} + {1'b0, m_ay};
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_s", rsp_s, sum7[5:0]);
                chk("rsp_cout", rsp_cout, sum7[6]);
            end
            // advance to the state after the coming rising edge
            if (!m_have) begin
                if (e_r0 || e_r1) begin
                    m_have = 1; m_age = 1; m_id = e_r1;
                    m_ax = e_r1 ? req1_x : req0_x;
                    m_ay = e_r1 ? req1_y : req0_y;
                    m_pref = !e_r1;
                end
            end else if (m_age >= 2) begin
                if (rsp_ready) begin
                    m_have = 0;
                    m_count = m_count + 1'b1;
                end
            end else begin
                m_age++;
            end
        end
    end

    // Called and returns at posedge+1; drops valid right after the accepting edge.
    task automatic issue(input logic id, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        bit got = 0;
        if (id) begin req1_valid = 1; req1_x = x; req1_y = y; end
        else    begin req0_valid = 1; req0_x = x; req0_y = y; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1;
            @(posedge clk); #1;
        end
        if (id) req1_valid = 0; else req0_valid = 0;
        if (!got) chk("issue_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int  nrsp;
        logic exp_id;

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // single op: 63 + 1 = 64 -> s=0, cout=1
        req0_valid = 1; req0_x = 6'b111111; req0_y = 6'b000001;
        @(negedge clk); chk("single_ready0", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk); chk("single_exec_valid", rsp_valid, 0);
        @(negedge clk);
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_s", rsp_s, 0);
        chk("single_cout", rsp_cout, 1);
        @(negedge clk);
        chk("single_count", op_count, 1);
        chk("single_idle", busy, 0);
        @(posedge clk); #1;

        // back-pressure: 20 + 22 held for five cycles while req0 waits
        rsp_ready = 0;
        issue(1, 6'd20, 6'd22);
        req0_valid = 1; req0_x = 6'd7; req0_y = 6'd8;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_s", rsp_s, 42);
            chk("bp_id", rsp_id, 1);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk); chk("bp_next_accept", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0; rsp_ready = 1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // reset during EXEC discards the op
        issue(0, 6'd9, 6'd9);
        rst_n = 0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_add_x", add_x, 0);
        chk("async_count", op_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_count", op_count, 0);
        end
        @(posedge clk); #1;

        // contention: both valid continuously
        req0_valid = 1; req0_x = 6'd10; req0_y = 6'd5;
        req1_valid = 1; req1_x = 6'd33; req1_y = 6'd40;
        nrsp = 0;
        for (int i = 0; i < 100 && nrsp < 4; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
`ifdef ADDER_ARB_RR_EN
                exp_id = nrsp[0];
`else
                exp_id = 1'b0;
`endif
                chk("cont_id", rsp_id, exp_id);
                chk("cont_s", rsp_s, exp_id ? 6'd9 : 6'd15);
                chk("cont_cout", rsp_cout, exp_id);
                nrsp++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        chk("cont_done", nrsp, 4);

        // exhaustive sweep alternating requesters
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] v;
            v = 12'(i);
            issue(v[0], v[11:6], v[5:0]);
        end
        repeat (3) @(negedge clk);
        chk("sweep_count_wrap", op_count, 0);
        chk("sweep_idle", busy, 0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
